// File: rtl/floor_call_register_if.sv
// Bus bundle for the floor call register: raw buttons, car position and
// service strobes go in; latched calls and summary flags come out.
// There is no valid/ready handshake on this bus: every input is a level
// sampled on each rising clk edge, and every output is valid at all times.
interface floor_call_register_if #(
    parameter int NUM_FLOORS = 3,
    parameter int FLOOR_W    = 2
) ();
    logic [NUM_FLOORS-1:0] button_n;
    logic [FLOOR_W-1:0]    floor;
    logic                  at_floor;
    logic                  clear_all;
    logic [NUM_FLOORS-1:0] led;
    logic                  pending;
    logic                  req_above;
    logic                  req_below;

    // Car controller side: drives buttons/position, reads calls.
    modport master (
        output button_n, floor, at_floor, clear_all,
        input  led, pending, req_above, req_below
    );

    // Call register side.
    modport slave (
        input  button_n, floor, at_floor, clear_all,
        output led, pending, req_above, req_below
    );
endinterface

// File: rtl/floor_call_register.sv
// Floor call register: synchronizes and debounces one active-low button per
// floor, latches a call on each new press, and clears calls when the car
// services that floor or when all calls are cancelled.
module floor_call_register #(
    parameter int NUM_FLOORS      = 3,
    parameter int FLOOR_W         = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    floor_call_register_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_FLOORS-1:0] s1;
    logic [NUM_FLOORS-1:0] s2;
    logic [NUM_FLOORS-1:0] deb;
    logic [NUM_FLOORS-1:0] toggle;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] led_q;
    logic [NUM_FLOORS-1:0] led_d;
    logic [CNT_W-1:0]      cnt [NUM_FLOORS];
    logic                  floor_valid;
    logic                  above;
    logic                  below;

    // An out-of-range floor index means the car is between/outside served
    // floors: it services nothing and has no direction relative to calls.
    assign floor_valid = ({1'b0, bus.floor} < (FLOOR_W + 1)'(NUM_FLOORS));

    // Two-flop synchronizer; reset to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= bus.button_n;
            s2 <= s1;
        end
    end

    // A channel toggles once its synchronized level has disagreed with the
    // debounced state for DEBOUNCE_CYCLES samples; only 0->1 is a press.
    always_comb begin
        toggle = '0;
        press  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (((~s2[i]) != deb[i]) && (cnt[i] == CNT_LAST)) begin
                toggle[i] = 1'b1;
                press[i]  = ~deb[i];
            end
        end
    end

    // Debounce state and stability counters per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if ((~s2[i]) == deb[i]) begin
                    cnt[i] <= '0;
                end else if (toggle[i]) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Next call state: presses set, clear_all or service at the current
    // floor clear, and clearing wins over a press on the same edge.
    always_comb begin
        led_d = led_q | press;
        if (bus.clear_all) begin
            led_d = '0;
        end else if (bus.at_floor && floor_valid) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (bus.floor == FLOOR_W'(i)) begin
                    led_d[i] = 1'b0;
                end
            end
        end
    end

    // Latched call register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    // Direction flags relative to the current floor, straight from led.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (led_q[i] && floor_valid) begin
                if ((FLOOR_W + 1)'(i) > {1'b0, bus.floor}) begin
                    above = 1'b1;
                end
                if ((FLOOR_W + 1)'(i) < {1'b0, bus.floor}) begin
                    below = 1'b1;
                end
            end
        end
    end

    assign bus.led       = led_q;
    assign bus.pending   = |led_q;
    assign bus.req_above = above;
    assign bus.req_below = below;
endmodule

// File: tb/tb_floor_call_register.sv
// Bench for floor_call_register with 3 floors and a 4-sample debounce:
// directed vector table, hand-written reset sequences and random traffic,
// all checked against a behavioural call model.
module tb_floor_call_register;
    localparam int NF = 3;
    localparam int DC = 4;

    logic clk;
    logic rst_n;

    floor_call_register_if #(.NUM_FLOORS(NF), .FLOOR_W(2)) bus ();

    floor_call_register #(
        .NUM_FLOORS(NF),
        .FLOOR_W(2),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired, required $finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // A button sample becomes visible to the debouncer two edges later; a
    // debounced level flips after DC consecutive visible samples disagree
    // with it; a new press latches a call; service and cancel clear calls.
    logic [NF-1:0] samp_q[$];
    logic [NF-1:0] m_deb;
    int            m_run[NF];
    logic [NF-1:0] m_led;
    logic [5:0]    exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic logic [5:0] expected_outputs(logic [NF-1:0] led, logic [1:0] fl);
        logic p, a, b;
        p = (led != 0);
        a = (fl < NF) && ((int'(led) >> (int'(fl) + 1)) != 0);
        b = (fl < NF) && ((int'(led) & ((1 << int'(fl)) - 1)) != 0);
        return {led, p, a, b};
    endfunction

    task automatic model_reset();
        samp_q = {};
        samp_q.push_back('1);
        samp_q.push_back('1);
        m_deb = '0;
        for (int i = 0; i < NF; i++) m_run[i] = 0;
        m_led = '0;
    endtask

    task automatic model_step(logic [NF-1:0] bn, logic [1:0] fl, logic af, logic ca, logic rst);
        logic [NF-1:0] vis;
        logic [NF-1:0] pr;
        logic          pressed;
        if (!rst) begin
            model_reset();
        end else begin
            vis = samp_q.pop_front();
            samp_q.push_back(bn);
            pr = '0;
            for (int i = 0; i < NF; i++) begin
                pressed = ~vis[i];
                if (pressed != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_deb[i] = pressed;
                        m_run[i] = 0;
                        if (pressed) pr[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_led = m_led | pr;
            if (ca) m_led = '0;
            else if (af && fl < NF) m_led[fl] = 1'b0;
        end
        exp_q.push_back(expected_outputs(m_led, fl));
    endtask

    // ---------------- scoreboard ----------------
    function automatic logic [5:0] dut_outputs();
        return {bus.led, bus.pending, bus.req_above, bus.req_below};
    endfunction

    task automatic check(string name, logic [5:0] act, logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: {led,pend,above,below} got %b required %b", name, $time, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(logic [NF-1:0] bn, logic [1:0] fl, logic af, logic ca);
        bus.button_n  = bn;
        bus.floor     = fl;
        bus.at_floor  = af;
        bus.clear_all = ca;
    endtask

    // One clock edge: model sees the inputs present at the edge, outputs
    // are compared 1 time unit later.
    task automatic tick(string name);
        logic [NF-1:0] c_bn;
        logic [1:0]    c_fl;
        logic          c_af, c_ca, c_rst;
        c_bn = bus.button_n; c_fl = bus.floor; c_af = bus.at_floor;
        c_ca = bus.clear_all; c_rst = rst_n;
        @(posedge clk);
        model_step(c_bn, c_fl, c_af, c_ca, c_rst);
        #1;
        check(name, dut_outputs(), exp_q.pop_front());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NF-1:0] bn;
        logic [1:0]    fl;
        logic          af;
        logic          ca;
        int            cycles;
        logic [NF-1:0] led;
        logic          pend;
        logic          above;
        logic          below;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [NF-1:0] bn, logic [1:0] fl, logic af, logic ca, int cyc,
                                logic [NF-1:0] led, logic p, logic a, logic b);
        vec_t v;
        v.bn = bn; v.fl = fl; v.af = af; v.ca = ca; v.cycles = cyc;
        v.led = led; v.pend = p; v.above = a; v.below = b;
        vecs.push_back(v);
    endfunction

    initial begin
        // Hold button 2 at floor 0: call appears on the 6th edge.
        add(3'b011, 2'd0, 0, 0, 5,  3'b000, 0, 0, 0);
        add(3'b011, 2'd0, 0, 0, 1,  3'b100, 1, 1, 0);
        add(3'b011, 2'd0, 0, 0, 8,  3'b100, 1, 1, 0);
        // Three-clock glitch on button 1 is rejected.
        add(3'b001, 2'd0, 0, 0, 3,  3'b100, 1, 1, 0);
        add(3'b011, 2'd0, 0, 0, 8,  3'b100, 1, 1, 0);
        // Real press on button 1 while 2 stays held.
        add(3'b001, 2'd0, 0, 0, 6,  3'b110, 1, 1, 0);
        add(3'b001, 2'd2, 0, 0, 1,  3'b110, 1, 0, 1);
        // Service floor 2 for one cycle; held button 2 does not re-latch.
        add(3'b001, 2'd2, 1, 0, 1,  3'b010, 1, 0, 1);
        add(3'b001, 2'd2, 0, 0, 10, 3'b010, 1, 0, 1);
        // Floor 1 with doors open: button 1 never latches, 0 and 2 together do.
        add(3'b111, 2'd1, 0, 0, 8,  3'b010, 1, 0, 0);
        add(3'b111, 2'd1, 1, 0, 1,  3'b000, 0, 0, 0);
        add(3'b101, 2'd1, 1, 0, 10, 3'b000, 0, 0, 0);
        add(3'b000, 2'd1, 1, 0, 5,  3'b000, 0, 0, 0);
        add(3'b000, 2'd1, 1, 0, 1,  3'b101, 1, 1, 1);
        // Build 111, then clear_all on the edge of a button-0 press.
        add(3'b111, 2'd1, 0, 0, 8,  3'b101, 1, 1, 1);
        add(3'b101, 2'd1, 0, 0, 6,  3'b111, 1, 1, 1);
        add(3'b100, 2'd1, 0, 0, 5,  3'b111, 1, 1, 1);
        add(3'b100, 2'd1, 0, 1, 1,  3'b000, 0, 0, 0);
        add(3'b100, 2'd1, 0, 0, 3,  3'b000, 0, 0, 0);
        // Floor 3 (out of range) with doors open clears nothing, no direction.
        add(3'b111, 2'd3, 1, 0, 8,  3'b000, 0, 0, 0);
        add(3'b011, 2'd3, 1, 0, 6,  3'b100, 1, 0, 0);
        add(3'b011, 2'd3, 1, 0, 3,  3'b100, 1, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [NF-1:0] rbn;
        logic [1:0]    rfl;
        logic          raf, rca;

        drive(3'b111, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #23;
        check("reset_state", dut_outputs(), expected_outputs(3'b000, 2'd0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[k]) begin
            drive(vecs[k].bn, vecs[k].fl, vecs[k].af, vecs[k].ca);
            for (int c = 0; c < vecs[k].cycles; c++) tick("vec_model");
            check($sformatf("vec%0d", k), dut_outputs(),
                  {vecs[k].led, vecs[k].pend, vecs[k].above, vecs[k].below});
        end

        // Build led=011, then assert reset between edges.
        drive(3'b011, 2'd3, 1'b1, 1'b1);
        tick("pre_async");
        drive(3'b100, 2'd3, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) tick("build_011");
        check("led_011", dut_outputs(), {3'b011, 1'b1, 1'b0, 1'b0});
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_outputs(), 6'b000000);
        tick("in_reset");
        rst_n = 1'b1;
        // Buttons still held after reset release register as a new press.
        for (int c = 0; c < 5; c++) tick("held_after_reset");
        check("held_before_6", dut_outputs(), 6'b000000);
        tick("held_edge6");
        check("held_after_6", dut_outputs(), {3'b011, 1'b1, 1'b0, 1'b0});

        // Reset mid-debounce discards the partial count.
        drive(3'b101, 2'd0, 1'b0, 1'b1);
        tick("clr");
        drive(3'b101, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) tick("mid_deb");
        #2; rst_n = 1'b0; model_reset();
        tick("mid_deb_rst");
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) tick("mid_deb_after");
        check("mid_deb_none", dut_outputs(), 6'b000000);
        tick("mid_deb_edge6");
        check("mid_deb_late", dut_outputs(), {3'b010, 1'b1, 1'b1, 1'b0});

        // Random traffic against the model.
        rbn = '1; rfl = 2'd0; raf = 1'b0; rca = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NF; i++)
                if ($urandom_range(0, 5) == 0) rbn[i] = ~rbn[i];
            if ($urandom_range(0, 9) == 0) rfl = 2'($urandom_range(0, 3));
            raf = ($urandom_range(0, 5) == 0);
            rca = ($urandom_range(0, 60) == 0);
            drive(rbn, rfl, raf, rca);
            if ($urandom_range(0, 400) == 0) begin
                rst_n = 1'b0;
                tick("rand_rst");
                rst_n = 1'b1;
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
